// File: rtl/regfile_pkg.sv
// Shared register-file types: index/data widths and the pending-write entry.
package regfile_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_lookup.sv
// Youngest-match search of the pending-write entries for one read-port index.
module wbq_fwd_lookup
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PTR_W-1:0]  head,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest from the head so the last match overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (entries[idx].dest == addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Pending-write FIFO draining into the register file write port, with read forwarding.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_dest,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   rf_stall,
  output logic                   rf_ld,
  output logic [ADDR_W-1:0]      rf_dest,
  output logic [DATA_W-1:0]      rf_data,
  input  logic [ADDR_W-1:0]      fwd_addr_a,
  input  logic [ADDR_W-1:0]      fwd_addr_b,
  output logic                   fwd_hit_a,
  output logic                   fwd_hit_b,
  output logic [DATA_W-1:0]      fwd_data_a,
  output logic [DATA_W-1:0]      fwd_data_b,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  import regfile_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             push;
  logic             pop;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign in_ready = !full;
  assign rf_ld    = !empty && !rf_stall;
  assign push     = in_valid && in_ready;
  assign pop      = rf_ld;
  assign rf_dest  = empty ? '0 : mem[head].dest;
  assign rf_data  = empty ? '0 : mem[head].data;

  // Storage needs no reset: the valid bits and count gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{dest: in_dest, data: in_data};
    end
  end

  // Push and pop never touch the same slot: that would need count 0 and DEPTH at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid   <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  wbq_fwd_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_a (
    .entries (mem),
    .valid   (valid),
    .head    (head),
    .addr    (fwd_addr_a),
    .hit     (fwd_hit_a),
    .data    (fwd_data_a)
  );

  wbq_fwd_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_b (
    .entries (mem),
    .valid   (valid),
    .head    (head),
    .addr    (fwd_addr_b),
    .hit     (fwd_hit_b),
    .data    (fwd_data_b)
  );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench: a queue model of pending writes predicts writes, occupancy and forwarding.
module tb_regfile_writeback_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_dest = '0;
  logic [31:0] in_data = '0;
  logic        rf_stall = 1'b0;
  logic        rf_ld;
  logic [3:0]  rf_dest;
  logic [31:0] rf_data;
  logic [3:0]  fwd_addr_a = '0;
  logic [3:0]  fwd_addr_b = '0;
  logic        fwd_hit_a;
  logic        fwd_hit_b;
  logic [31:0] fwd_data_a;
  logic [31:0] fwd_data_b;
  logic [2:0]  count;
  logic        empty;

  regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dest    (in_dest),
    .in_data    (in_data),
    .rf_stall   (rf_stall),
    .rf_ld      (rf_ld),
    .rf_dest    (rf_dest),
    .rf_data    (rf_data),
    .fwd_addr_a (fwd_addr_a),
    .fwd_addr_b (fwd_addr_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b),
    .count      (count),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // pend: writes not yet retired; exp_wr: writes the monitor still expects to see
  wb_entry_t pend[$];
  wb_entry_t exp_wr[$];
  int compared = 0;
  int mismatched = 0;

  function automatic void check_output(string name, logic [63:0] act, logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic void ref_fwd(input logic [3:0] addr, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].dest == addr) begin
        hit  = 1'b1;
        data = pend[i].data;
      end
    end
  endfunction

  // One cycle: drive inputs, then apply the FIFO rules to the model at the edge.
  task automatic apply_stimulus(input logic v, input logic [3:0] d, input logic [31:0] x,
                                input logic stall);
    bit acc;
    bit popped;
    in_valid = v;
    in_dest  = d;
    in_data  = x;
    rf_stall = stall;
    @(posedge clk);
    acc    = in_valid && (pend.size() < DEPTH);
    popped = (pend.size() > 0) && !rf_stall;
    if (popped) void'(pend.pop_front());
    if (acc) begin
      pend.push_back('{dest: in_dest, data: in_data});
      exp_wr.push_back('{dest: in_dest, data: in_data});
    end
    #1;
  endtask

  logic      m_hit;
  logic [31:0] m_data;
  wb_entry_t m_e;

  always @(negedge clk) begin
    if (reset_n) begin
      check_output("count", 64'(count), 64'(pend.size()));
      check_output("in_ready", 64'(in_ready), 64'(pend.size() < DEPTH));
      check_output("empty", 64'(empty), 64'(pend.size() == 0));
      check_output("rf_ld", 64'(rf_ld), 64'((pend.size() != 0) && !rf_stall));
      if (rf_ld) begin
        check_output("write_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          m_e = exp_wr.pop_front();
          check_output("rf_dest", 64'(rf_dest), 64'(m_e.dest));
          check_output("rf_data", 64'(rf_data), 64'(m_e.data));
        end
      end else if (pend.size() == 0) begin
        check_output("rf_dest_idle", 64'(rf_dest), 64'd0);
        check_output("rf_data_idle", 64'(rf_data), 64'd0);
      end
      ref_fwd(fwd_addr_a, m_hit, m_data);
      check_output("fwd_hit_a", 64'(fwd_hit_a), 64'(m_hit));
      check_output("fwd_data_a", 64'(fwd_data_a), 64'(m_data));
      ref_fwd(fwd_addr_b, m_hit, m_data);
      check_output("fwd_hit_b", 64'(fwd_hit_b), 64'(m_hit));
      check_output("fwd_data_b", 64'(fwd_data_b), 64'(m_data));
    end
  end

  initial begin
    #2;
    check_output("rst_rf_ld", 64'(rf_ld), 64'd0);
    check_output("rst_empty", 64'(empty), 64'd1);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);
    check_output("rst_count", 64'(count), 64'd0);
    check_output("rst_rf_dest", 64'(rf_dest), 64'd0);
    check_output("rst_rf_data", 64'(rf_data), 64'd0);
    check_output("rst_fwd_hit_a", 64'(fwd_hit_a), 64'd0);
    check_output("rst_fwd_data_b", 64'(fwd_data_b), 64'd0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single write");
    fwd_addr_a = 4'd5;
    apply_stimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b0);
    check_output("t1_rf_ld", 64'(rf_ld), 64'd1);
    check_output("t1_rf_dest", 64'(rf_dest), 64'd5);
    check_output("t1_rf_data", 64'(rf_data), 64'hDEADBEEF);
    check_output("t1_fwd_hit", 64'(fwd_hit_a), 64'd1);
    apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);
    check_output("t1_empty_after", 64'(empty), 64'd1);

    $display("[TB] fill under stall");
    for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, 4'(i), 32'(i * 16'h0101), 1'b1);
    check_output("t2_count_full", 64'(count), 64'd4);
    check_output("t2_in_ready_full", 64'(in_ready), 64'd0);
    apply_stimulus(1'b1, 4'd9, 32'h99, 1'b1);
    check_output("t2_count_after_fifth", 64'(count), 64'd4);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);

    $display("[TB] duplicate destination forwarding");
    fwd_addr_a = 4'd7;
    fwd_addr_b = 4'd8;
    apply_stimulus(1'b1, 4'd7, 32'h11, 1'b1);
    apply_stimulus(1'b1, 4'd7, 32'h22, 1'b1);
    check_output("t3_fwd_hit_a", 64'(fwd_hit_a), 64'd1);
    check_output("t3_fwd_data_a", 64'(fwd_data_a), 64'h22);
    check_output("t3_fwd_hit_b", 64'(fwd_hit_b), 64'd0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);
    check_output("t3_fwd_hit_a_gone", 64'(fwd_hit_a), 64'd0);

    $display("[TB] streaming with wrap");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 4'(i + 3), 32'hA000 + 32'(i), 1'b0);
      check_output("t4_count_stream", 64'(count), 64'd1);
    end
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);

    $display("[TB] reset with pending writes");
    fwd_addr_a = 4'd3;
    for (int i = 2; i <= 4; i++) apply_stimulus(1'b1, 4'(i), 32'hB0 + 32'(i), 1'b1);
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check_output("t5_rf_ld_async", 64'(rf_ld), 64'd0);
    check_output("t5_count_async", 64'(count), 64'd0);
    check_output("t5_fwd_hit_async", 64'(fwd_hit_a), 64'd0);
    pend.delete();
    exp_wr.delete();
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      fwd_addr_a = 4'($urandom_range(0, 15));
      fwd_addr_b = 4'($urandom_range(0, 15));
      apply_stimulus(1'($urandom_range(0, 99) < 65), 4'($urandom_range(0, 15)), $urandom,
                     1'($urandom_range(0, 99) < 30));
    end
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);
    check_output("drained", 64'(exp_wr.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
